// File: rtl/spi_tx_if.sv
// Bundle between game logic and the SPI transmitter: word/trigger in, three-wire link plus status out.
// master = transmitter side, slave = the logic that feeds it and watches the link.
interface spi_tx_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] data_in;
  logic                  trigger_in;
  logic                  data_out;
  logic                  data_clk_out;
  logic                  sel_out;
  logic                  busy_out;
  logic                  done_out;

  modport master (
    input  data_in, trigger_in,
    output data_out, data_clk_out, sel_out, busy_out, done_out
  );

  modport slave (
    output data_in, trigger_in,
    input  data_out, data_clk_out, sel_out, busy_out, done_out
  );
endinterface

// File: rtl/spi_tx.sv
// SPI mode-0 master: one DATA_WIDTH word per accepted trigger, MSB first, then a HALF-cycle deselected gap.
// Frame takes 2*HALF*W + HALF cycles; triggers while busy are dropped (no queueing, no backpressure).
module spi_tx #(
  parameter int DATA_WIDTH      = 32,
  parameter int DATA_CLK_PERIOD = 8
) (
  input  logic     clk_pixel_in,
  input  logic     rst_in,
  spi_tx_if.master bus
);
  localparam int HALF = DATA_CLK_PERIOD / 2;
  localparam int CW   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int BW   = $clog2(DATA_WIDTH + 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
  localparam logic [BW-1:0] BITS      = BW'(DATA_WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    GAP
  } state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]         half_cnt_q, half_cnt_d;
  logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
  logic                  data_q, data_d;
  logic                  sclk_q, sclk_d;
  logic                  sel_q, sel_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic [DATA_WIDTH-1:0] shifted;
  logic [BW-1:0]         bit_cnt_inc;

  always_ff @(posedge clk_pixel_in) begin
    if (rst_in) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      half_cnt_q <= '0;
      bit_cnt_q  <= '0;
      data_q     <= 1'b0;
      sclk_q     <= 1'b0;
      sel_q      <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      half_cnt_q <= half_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      data_q     <= data_d;
      sclk_q     <= sclk_d;
      sel_q      <= sel_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    half_cnt_d  = half_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    data_d      = data_q;
    sclk_d      = sclk_q;
    sel_d       = sel_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    shifted     = shift_q << 1;
    bit_cnt_inc = bit_cnt_q + 1'b1;

    case (state_q)
      IDLE: begin
        if (bus.trigger_in) begin
          shift_d    = bus.data_in;
          data_d     = bus.data_in[DATA_WIDTH-1];
          sel_d      = 1'b0;
          busy_d     = 1'b1;
          half_cnt_d = '0;
          bit_cnt_d  = '0;
          sclk_d     = 1'b0;
          state_d    = SHIFT;
        end
      end

      SHIFT: begin
        if (half_cnt_q == HALF_LAST) begin
          half_cnt_d = '0;
          sclk_d     = ~sclk_q;
          // Data only moves on the falling edge so it is centred on the receiver's rising-edge sample.
          if (sclk_q) begin
            bit_cnt_d = bit_cnt_inc;
            if (bit_cnt_inc < BITS) begin
              shift_d = shifted;
              data_d  = shifted[DATA_WIDTH-1];
            end else begin
              sel_d   = 1'b1;
              data_d  = 1'b0;
              state_d = GAP;
            end
          end
        end else begin
          half_cnt_d = half_cnt_q + 1'b1;
        end
      end

      GAP: begin
        if (half_cnt_q == HALF_LAST) begin
          half_cnt_d = '0;
          bit_cnt_d  = '0;
          busy_d     = 1'b0;
          done_d     = 1'b1;
          state_d    = IDLE;
        end else begin
          half_cnt_d = half_cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        sel_d   = 1'b1;
        sclk_d  = 1'b0;
        data_d  = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign bus.data_out     = data_q;
  assign bus.data_clk_out = sclk_q;
  assign bus.sel_out      = sel_q;
  assign bus.busy_out     = busy_q;
  assign bus.done_out     = done_q;
endmodule

// File: tb/tb_spi_tx.sv
// Bench for spi_tx: two instances (W=8/period 4 and W=32/period 2) checked cycle by cycle against
// an arithmetic waveform model and a rising-edge receiver model.
module tb_spi_tx;
  localparam int WA = 8;
  localparam int PA = 4;
  localparam int HA = PA / 2;
  localparam int WB = 32;
  localparam int PB = 2;
  localparam int HB = PB / 2;

  logic clk = 1'b0;
  logic rst;
  int   n_chk = 0;
  int   n_err = 0;

  spi_tx_if #(.DATA_WIDTH(WA)) bus_a ();
  spi_tx_if #(.DATA_WIDTH(WB)) bus_b ();

  spi_tx #(.DATA_WIDTH(WA), .DATA_CLK_PERIOD(PA)) dut_a (
    .clk_pixel_in (clk),
    .rst_in       (rst),
    .bus          (bus_a)
  );

  spi_tx #(.DATA_WIDTH(WB), .DATA_CLK_PERIOD(PB)) dut_b (
    .clk_pixel_in (clk),
    .rst_in       (rst),
    .bus          (bus_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected {sel, sclk, data, busy, done} in the cycle after edge T0+t.
  function automatic logic [4:0] model(input logic [31:0] w, input int W, input int H, input int t);
    int   fl;
    logic s, c, d, b, dn;
    fl = 2 * H * W;
    if (t < fl) begin
      s = 1'b0;
      c = ((t / H) % 2) == 1;
      d = w[W - 1 - t / (2 * H)];
    end else begin
      s = 1'b1;
      c = 1'b0;
      d = 1'b0;
    end
    b  = (t < fl + H);
    dn = (t == fl + H);
    return {s, c, d, b, dn};
  endfunction

  function automatic logic [4:0] get_outs(input int which);
    if (which == 0)
      return {bus_a.sel_out, bus_a.data_clk_out, bus_a.data_out, bus_a.busy_out, bus_a.done_out};
    return {bus_b.sel_out, bus_b.data_clk_out, bus_b.data_out, bus_b.busy_out, bus_b.done_out};
  endfunction

  task automatic drive(input int which, input logic trig, input logic [31:0] data);
    if (which == 0) begin
      bus_a.trigger_in = trig;
      bus_a.data_in    = data[WA-1:0];
    end else begin
      bus_b.trigger_in = trig;
      bus_b.data_in    = data;
    end
  endtask

  task automatic chk_outs(input string nm, input int t, input logic [4:0] obs, input logic [4:0] exp);
    string fld[5] = '{"sel", "sclk", "sdata", "busy", "done"};
    for (int i = 0; i < 5; i++)
      chk($sformatf("%s %s t=%0d", nm, fld[i], t), 32'(obs[4-i]), 32'(exp[4-i]));
  endtask

  // One frame; when start=0 the trigger was already accepted at the previous edge.
  // hold keeps trigger high so the next frame is accepted right after this one.
  task automatic run_frame(input int which, input logic [31:0] word, input bit start, input bit hold,
                           input logic [31:0] after, input int g1, input int g2);
    int          w = (which == 0) ? WA : WB;
    int          h = (which == 0) ? HA : HB;
    int          len = 2 * h * w + h;
    string       nm = (which == 0) ? "A" : "B";
    logic [4:0]  o;
    logic        prev_sclk = 1'b0;
    logic [31:0] rx = '0;
    int          rises = 0, n_busy = 0, n_sel = 0, n_done = 0;
    if (start) begin
      drive(which, 1'b1, word);
      tick();
    end
    for (int t = 0; t <= len; t++) begin
      o = get_outs(which);
      chk_outs(nm, t, o, model(word, w, h, t));
      if (o[3] && !prev_sclk && !o[4]) begin
        rx = {rx[30:0], o[2]};
        rises++;
      end
      prev_sclk = o[3];
      n_busy += int'(o[1]);
      n_sel  += int'(!o[4]);
      n_done += int'(o[0]);
      drive(which, hold || (t + 1 == g1) || (t + 1 == g2), after);
      tick();
    end
    chk({nm, " rx word"}, rx, word);
    chk({nm, " rises"}, 32'(rises), 32'(w));
    chk({nm, " busy cycles"}, 32'(n_busy), 32'(2 * h * w + h));
    chk({nm, " sel low cycles"}, 32'(n_sel), 32'(2 * h * w));
    chk({nm, " done pulses"}, 32'(n_done), 32'd1);
    if (!hold) chk_outs({nm, " idle"}, len + 1, get_outs(which), 5'b10000);
  endtask

  initial begin
    logic [31:0] wd;
    bit          prev_hold;
    bit          hold;
    rst = 1'b1;
    drive(0, 1'b0, '0);
    drive(1, 1'b0, '0);
    repeat (3) tick();
    chk_outs("A reset", 0, get_outs(0), 5'b10000);
    chk_outs("B reset", 0, get_outs(1), 5'b10000);
    rst = 1'b0;
    tick();

    run_frame(0, 32'hA5, 1'b1, 1'b0, 32'($urandom_range(0, 255)), 0, 0);
    tick();

    // Trigger held high across two frames, data changed after acceptance.
    run_frame(0, 32'hFF, 1'b1, 1'b1, 32'h00, 0, 0);
    run_frame(0, 32'h00, 1'b0, 1'b0, 32'h00, 0, 0);
    tick();

    run_frame(0, 32'($urandom_range(0, 255)), 1'b1, 1'b0, 32'($urandom_range(0, 255)), 5, 20);
    // Trigger on the very edge where busy falls must be ignored.
    run_frame(0, 32'($urandom_range(0, 255)), 1'b1, 1'b0, 32'($urandom_range(0, 255)),
              2 * HA * WA + HA, 0);

    // Reset mid-frame, sampled at edge T0+13.
    wd = 32'($urandom_range(0, 255));
    drive(0, 1'b1, wd);
    tick();
    drive(0, 1'b0, wd);
    for (int t = 0; t < 13; t++) begin
      chk_outs("A pre-rst", t, get_outs(0), model(wd, WA, HA, t));
      if (t == 12) rst = 1'b1;
      tick();
    end
    chk_outs("A after rst", 13, get_outs(0), 5'b10000);
    rst = 1'b0;
    tick();
    chk_outs("A idle post-rst", 0, get_outs(0), 5'b10000);
    run_frame(0, 32'h3C, 1'b1, 1'b0, 32'h00, 0, 0);

    for (int i = 0; i < 20; i++) begin
      run_frame(0, 32'($urandom_range(0, 255)), 1'b1, 1'b0, 32'($urandom_range(0, 255)),
                int'($urandom_range(1, 2 * HA * WA + HA)), int'($urandom_range(1, 2 * HA * WA + HA)));
      repeat ($urandom_range(0, 2)) tick();
    end

    run_frame(1, 32'h8000_0001, 1'b1, 1'b0, $urandom, 0, 0);
    tick();

    prev_hold = 1'b0;
    wd = $urandom;
    for (int i = 0; i < 100; i++) begin
      hold = (i < 99) && ($urandom_range(0, 1) == 1);
      run_frame(1, wd, !prev_hold, hold, hold ? $urandom : 32'h0,
                int'($urandom_range(1, 2 * HB * WB + HB)), 0);
      // When holding, the word presented during the last cycle is what the next frame latches.
      wd = hold ? bus_b.data_in : $urandom;
      if (!hold) repeat ($urandom_range(0, 3)) tick();
      prev_hold = hold;
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
